// File: rtl/wbuf_pkg.sv
// Shared types for the posted-write buffer: FSM states, access sizes and the FIFO entry layout.
package wbuf_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWrReq,
    StWrWait,
    StRdReq,
    StRdWait
  } state_e;

  localparam logic [1:0] SizeByte = 2'd0;
  localparam logic [1:0] SizeHalf = 2'd1;
  localparam logic [1:0] SizeWord = 2'd2;

  typedef struct packed {
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } entry_t;

endpackage

// File: rtl/wbuf_fifo.sv
// Posted-write storage: circular FIFO of entry_t with occupancy count.
// With WBUF_READ_BYPASS_EN defined it also exposes a per-entry word-address match vector.
module wbuf_fifo
  import wbuf_pkg::*;
#(
  parameter int unsigned Depth = 4,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  entry_t           push_entry_i,
  input  logic             pop_i,
`ifdef WBUF_READ_BYPASS_EN
  input  logic [29:0]      match_word_i,
  output logic [Depth-1:0] match_o,
`endif
  output entry_t           head_o,
  output logic             full_o,
  output logic             empty_o
);

  entry_t          mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic            do_push, do_pop;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign head_o  = mem_q[rd_ptr_q];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  // Payload needs no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_entry_i;
  end

`ifdef WBUF_READ_BYPASS_EN
  logic [Depth-1:0] valid_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
    end else begin
      if (do_pop)  valid_q[rd_ptr_q] <= 1'b0;
      if (do_push) valid_q[wr_ptr_q] <= 1'b1;
    end
  end

  always_comb begin
    for (int i = 0; i < Depth; i++) begin
      match_o[i] = valid_q[i] & (mem_q[i].addr[31:2] == match_word_i);
    end
  end
`endif

endmodule

// File: rtl/write_buffer.sv
// Posted write buffer between the data arbiter and the AXI bridge; reads wait for the drain
// unless WBUF_READ_BYPASS_EN is defined, which lets non-conflicting reads overtake buffered writes.
module write_buffer
  import wbuf_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        up_req_i,
  input  logic        up_wr_i,
  input  logic [1:0]  up_size_i,
  input  logic [31:0] up_addr_i,
  input  logic [31:0] up_wdata_i,
  output logic [31:0] up_rdata_o,
  output logic        up_addr_ok_o,
  output logic        up_data_ok_o,
  output logic        dn_req_o,
  output logic        dn_wr_o,
  output logic [1:0]  dn_size_o,
  output logic [31:0] dn_addr_o,
  output logic [31:0] dn_wdata_o,
  input  logic [31:0] dn_rdata_i,
  input  logic        dn_addr_ok_i,
  input  logic        dn_data_ok_i,
  output logic        empty_o
);

  state_e state_q, state_d;
  logic   wr_ack_q;
  logic   fifo_full, fifo_empty, push, pop;
  logic   rd_pending, rd_permitted, rd_busy, wr_accept;
  logic   rd_addr_ok, rd_data_ok;
  entry_t head, push_entry;

  assign push_entry = '{size: up_size_i, addr: up_addr_i, wdata: up_wdata_i};
  assign rd_pending = up_req_i & ~up_wr_i;
  assign rd_busy    = (state_q == StRdReq) || (state_q == StRdWait);
  // Fullness is taken from registered count, so a same-cycle pop never frees a slot early.
  assign wr_accept  = up_req_i & up_wr_i & ~fifo_full & ~rd_busy;
  assign push       = wr_accept;
  assign pop        = (state_q == StWrWait) & dn_data_ok_i;
  assign empty_o    = fifo_empty & (state_q != StWrReq) & (state_q != StWrWait);

`ifdef WBUF_READ_BYPASS_EN
  logic [DEPTH-1:0] match;
  assign rd_permitted = ~|match;
`else
  assign rd_permitted = empty_o;
`endif

  wbuf_fifo #(
    .Depth(DEPTH)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (push),
    .push_entry_i(push_entry),
    .pop_i       (pop),
`ifdef WBUF_READ_BYPASS_EN
    .match_word_i(up_addr_i[31:2]),
    .match_o     (match),
`endif
    .head_o      (head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      wr_ack_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ack_q <= wr_accept;
    end
  end

  always_comb begin
    state_d    = state_q;
    dn_req_o   = 1'b0;
    dn_wr_o    = 1'b0;
    dn_size_o  = head.size;
    dn_addr_o  = head.addr;
    dn_wdata_o = head.wdata;
    rd_addr_ok = 1'b0;
    rd_data_ok = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (rd_pending && rd_permitted) state_d = StRdReq;
        else if (!fifo_empty)           state_d = StWrReq;
      end
      StWrReq: begin
        dn_req_o = 1'b1;
        dn_wr_o  = 1'b1;
        if (dn_addr_ok_i) state_d = StWrWait;
      end
      StWrWait: begin
        if (dn_data_ok_i) state_d = StIdle;
      end
      StRdReq: begin
        dn_req_o   = 1'b1;
        dn_size_o  = up_size_i;
        dn_addr_o  = up_addr_i;
        dn_wdata_o = up_wdata_i;
        rd_addr_ok = dn_addr_ok_i;
        if (dn_addr_ok_i) state_d = StRdWait;
      end
      StRdWait: begin
        rd_data_ok = dn_data_ok_i;
        if (dn_data_ok_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign up_rdata_o   = dn_rdata_i;
  assign up_addr_ok_o = wr_accept | rd_addr_ok;
  assign up_data_ok_o = wr_ack_q | rd_data_ok;

endmodule

// File: tb/tb_write_buffer.sv
// Scoreboard bench for write_buffer; expectations adapt to WBUF_READ_BYPASS_EN.
module tb_write_buffer;
  import wbuf_pkg::*;

  localparam int unsigned Depth = 4;
`ifdef WBUF_READ_BYPASS_EN
  localparam bit Byp = 1'b1;
`else
  localparam bit Byp = 1'b0;
`endif

  logic        clk, rst;
  logic        up_req, up_wr, up_addr_ok, up_data_ok;
  logic [1:0]  up_size, dn_size;
  logic [31:0] up_addr, up_wdata, up_rdata;
  logic        dn_req, dn_wr, dn_addr_ok, dn_data_ok, empty;
  logic [31:0] dn_addr, dn_wdata, dn_rdata;

  write_buffer #(
    .DEPTH(Depth)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .up_req_i    (up_req),
    .up_wr_i     (up_wr),
    .up_size_i   (up_size),
    .up_addr_i   (up_addr),
    .up_wdata_i  (up_wdata),
    .up_rdata_o  (up_rdata),
    .up_addr_ok_o(up_addr_ok),
    .up_data_ok_o(up_data_ok),
    .dn_req_o    (dn_req),
    .dn_wr_o     (dn_wr),
    .dn_size_o   (dn_size),
    .dn_addr_o   (dn_addr),
    .dn_wdata_o  (dn_wdata),
    .dn_rdata_i  (dn_rdata),
    .dn_addr_ok_i(dn_addr_ok),
    .dn_data_ok_i(dn_data_ok),
    .empty_o     (empty)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  entry_t      exp_wr[$];
  logic [31:0] exp_rd[$];
  logic [31:0] prog_mem[logic [29:0]];
  logic [31:0] dn_mem[logic [29:0]];

  bit dn_stall = 1'b0;
  int wr_dly = 0, rd_dly = 0;
  int cyc = 0, dn_hs = 0, wr_pops = 0;
  bit pop_now = 1'b0;
  int exp_pend_rd = -1;
  int rd_acc_cyc = 0, rd_done_cyc = 0;
  bit rd_out = 1'b0, wr_acc_prev = 1'b0;
  int last_wait, last_cyc, last_pops;
  bit last_popnow;

  function automatic logic [31:0] dflt_rd(input logic [29:0] w);
    return {w, 2'b00} ^ 32'h5A5A_0000;
  endfunction

  // Downstream model: addr_ok unless stalled, data_ok after a programmable delay.
  initial begin
    bit          pend, pend_wr, hz;
    int          pend_wait;
    logic [31:0] pend_data;
    entry_t      e;
    pend = 0; pend_wr = 0; pend_wait = 0; pend_data = '0;
    dn_addr_ok = 1'b0; dn_data_ok = 1'b0; dn_rdata = '0;
    forever begin
      @(negedge clk);
      cyc++;
      pop_now    = 1'b0;
      dn_data_ok = 1'b0;
      if (rst) begin
        pend       = 0;
        dn_addr_ok = 1'b0;
      end else begin
        if (pend) begin
          if (pend_wait == 0) begin
            dn_data_ok = 1'b1;
            dn_rdata   = pend_data;
            pend       = 0;
            if (pend_wr) begin
              pop_now = 1'b1;
              wr_pops++;
            end
          end else begin
            pend_wait--;
          end
        end
        dn_addr_ok = !dn_stall;
        #4;
        if (!rst && dn_req && dn_addr_ok) begin
          dn_hs++;
          if (dn_wr) begin
            check("dn_wr_expected", exp_wr.size() > 0, 1);
            if (exp_wr.size() > 0) begin
              e = exp_wr.pop_front();
              check("dn_wr_addr", dn_addr, e.addr);
              check("dn_wr_data", dn_wdata, e.wdata);
              check("dn_wr_size", dn_size, e.size);
            end
            dn_mem[dn_addr[31:2]] = dn_wdata;
            pend_data = '0;
            pend_wait = wr_dly;
          end else begin
            check("dn_rd_addr", dn_addr, up_addr);
            if (exp_pend_rd >= 0) check("rd_pending_writes", exp_wr.size(), exp_pend_rd);
            hz = 0;
            foreach (exp_wr[i]) if (exp_wr[i].addr[31:2] == dn_addr[31:2]) hz = 1;
            check("rd_raw_hazard", hz, 0);
            pend_data = dn_mem.exists(dn_addr[31:2]) ? dn_mem[dn_addr[31:2]]
                                                     : dflt_rd(dn_addr[31:2]);
            pend_wait = rd_dly;
          end
          pend    = 1;
          pend_wr = dn_wr;
        end
      end
    end
  end

  // Upstream response monitor.
  initial begin
    forever begin
      @(negedge clk);
      #4;
      if (rst) begin
        wr_acc_prev = 1'b0;
        rd_out      = 1'b0;
      end else begin
        if (wr_acc_prev) check("wr_data_ok", up_data_ok, 1);
        else if (!rd_out) check("no_spurious_data_ok", up_data_ok, 0);
        if (rd_out && up_data_ok) begin
          check("rd_queued", exp_rd.size() > 0, 1);
          if (exp_rd.size() > 0) check("rd_data", up_rdata, exp_rd.pop_front());
          check("rd_wr_data_ok_overlap", wr_acc_prev, 0);
          rd_out      = 1'b0;
          rd_done_cyc = cyc;
        end
        if (up_req && !up_wr && up_addr_ok) begin
          rd_out     = 1'b1;
          rd_acc_cyc = cyc;
        end
        wr_acc_prev = up_req & up_wr & up_addr_ok;
      end
    end
  end

  task automatic up_write(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    int     w = 0;
    bit     done = 0;
    entry_t e;
    up_req = 1'b1; up_wr = 1'b1; up_addr = a; up_wdata = d; up_size = s;
    while (!done && w < 200) begin
      #4;
      if (up_addr_ok) begin
        done = 1;
        e.size = s; e.addr = a; e.wdata = d;
        exp_wr.push_back(e);
        prog_mem[a[31:2]] = d;
        last_cyc    = cyc;
        last_popnow = pop_now;
        last_pops   = wr_pops;
      end
      @(negedge clk);
      if (!done) w++;
    end
    last_wait = w;
    check("wr_accepted", done, 1);
    if (!done) up_req = 1'b0;
  endtask

  task automatic up_read(input logic [31:0] a, input logic [1:0] s);
    int w = 0;
    bit done = 0;
    up_req = 1'b1; up_wr = 1'b0; up_addr = a; up_wdata = '0; up_size = s;
    exp_rd.push_back(prog_mem.exists(a[31:2]) ? prog_mem[a[31:2]] : dflt_rd(a[31:2]));
    while (!done && w < 200) begin
      #4;
      if (up_addr_ok) done = 1;
      @(negedge clk);
      if (!done) w++;
    end
    check("rd_accepted", done, 1);
    if (!done) up_req = 1'b0;
  endtask

  task automatic idle();
    up_req = 1'b0;
    up_wr  = 1'b0;
  endtask

  task automatic wait_drained();
    bit ok = 0;
    for (int k = 0; k < 300 && !ok; k++) begin
      #4;
      ok = empty && (exp_wr.size() == 0) && !rd_out && (exp_rd.size() == 0);
      @(negedge clk);
    end
    check("drained", ok, 1);
  endtask

  initial begin
    int hs0;
    bit ok;
    rst = 1'b1;
    up_req = 1'b0; up_wr = 1'b0; up_size = '0; up_addr = '0; up_wdata = '0;

    @(negedge clk);
    #4;
    check("rst_empty", empty, 1);
    check("rst_dn_req", dn_req, 0);
    check("rst_up_addr_ok", up_addr_ok, 0);
    check("rst_up_data_ok", up_data_ok, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #4;
    check("post_rst_dn_req", dn_req, 0);
    check("post_rst_empty", empty, 1);
    @(negedge clk);

    // In-order drain with sizes preserved
    up_write(32'h100, 32'h11, SizeWord);
    up_write(32'h104, 32'h22, SizeHalf);
    up_write(32'h108, 32'h33, SizeByte);
    idle();
    wait_drained();

    // Fill to DEPTH with downstream stalled; fifth write waits for the first pop
    dn_stall = 1'b1;
    wr_pops  = 0;
    for (int i = 0; i < 4; i++) begin
      up_write(32'h800 + 32'(i * 4), 32'hA0 + 32'(i), SizeWord);
      check("fill_no_wait", last_wait, 0);
    end
    fork
      up_write(32'h810, 32'hA4, SizeWord);
      begin
        repeat (6) @(negedge clk);
        dn_stall = 1'b0;
      end
    join
    check("fill5_waited", last_wait >= 6, 1);
    check("fill5_after_one_pop", last_pops, 1);
    check("fill5_not_in_pop_cycle", last_popnow, 0);
    idle();
    wait_drained();

    // Non-matching read with writes buffered
    dn_stall = 1'b1;
    up_write(32'h200, 32'h0000_0200, SizeWord);
    up_write(32'h204, 32'h0000_0204, SizeWord);
    dn_stall = 1'b0;
    exp_pend_rd = Byp ? 1 : 0;
    up_read(32'h300, SizeWord);
    idle();
    wait_drained();

    // Matching read behind an unrelated write must see the written data
    dn_stall = 1'b1;
    up_write(32'h208, 32'h0000_0208, SizeWord);
    up_write(32'h200, 32'hCAFE_0200, SizeWord);
    dn_stall = 1'b0;
    exp_pend_rd = 0;
    up_read(32'h202, SizeHalf);
    idle();
    wait_drained();
    exp_pend_rd = -1;

    // Write presented while a read is outstanding
    rd_dly = 3;
    up_read(32'h600, SizeWord);
    up_write(32'h604, 32'h66, SizeWord);
    check("wr_after_rd_done", rd_done_cyc > rd_acc_cyc, 1);
    check("wr_acc_cycle", last_cyc, rd_done_cyc + 1);
    idle();
    rd_dly = 0;
    wait_drained();

    // Reset while draining discards everything
    dn_stall = 1'b1;
    wr_dly   = 4;
    up_write(32'h700, 32'h70, SizeWord);
    up_write(32'h704, 32'h71, SizeWord);
    up_write(32'h708, 32'h72, SizeWord);
    idle();
    hs0 = dn_hs;
    dn_stall = 1'b0;
    ok = 0;
    for (int k = 0; k < 50 && !ok; k++) begin
      #4;
      ok = (dn_hs > hs0);
      @(negedge clk);
    end
    check("drain_started", ok, 1);
    rst = 1'b1;
    #4;
    check("midrst_dn_req", dn_req, 0);
    check("midrst_empty", empty, 1);
    check("midrst_up_data_ok", up_data_ok, 0);
    @(negedge clk);
    exp_wr.delete();
    @(negedge clk);
    rst = 1'b0;
    hs0 = dn_hs;
    repeat (20) @(negedge clk);
    #4;
    check("no_dn_after_rst", dn_hs - hs0, 0);
    check("post_midrst_empty", empty, 1);
    check("post_midrst_dn_req", dn_req, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
